// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver (DATA_WIDTH data bits, no parity) with AXI-Stream output and error pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic                  rxd_m_q, rxd_s_q;
    logic                  armed_q, armed_d;
    logic [18:0]           timer_q, timer_d, period_q, period_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, tdata_q, tdata_d;
    logic [DATA_WIDTH:0]   shift_ext;
    logic                  tvalid_q, tvalid_d, overrun_q, overrun_d, frame_q, frame_d;
    logic                  tick;

    assign tick      = timer_q == 19'd0;
    assign shift_ext = {rxd_s_q, shift_q};

    always_comb begin
        state_d   = state_q;
        armed_d   = 1'b0;
        timer_d   = (state_q != IDLE && !tick) ? timer_q - 19'd1 : timer_q;
        period_d  = period_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q && !m_axis_tready;
        overrun_d = 1'b0;
        frame_d   = 1'b0;
        case (state_q)
            IDLE: begin
                armed_d = armed_q | rxd_s_q;
                if (armed_q && !rxd_s_q && prescale != 16'd0) begin
                    state_d  = START;
                    armed_d  = 1'b0;
                    period_d = {prescale, 3'b000};
                    timer_d  = {1'b0, prescale, 2'b00} - 19'd1;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = rxd_s_q ? IDLE : DATA;
                    timer_d   = period_q - 19'd1;
                    bit_cnt_d = 4'(DATA_WIDTH);
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_ext[DATA_WIDTH:1];
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    timer_d   = period_q - 19'd1;
                    state_d   = (bit_cnt_q == 4'd1) ? STOP : DATA;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    // a handshake in the same cycle frees the slot, so only an unconsumed word is overrun
                    if (rxd_s_q) begin
                        tdata_d   = shift_q;
                        tvalid_d  = 1'b1;
                        overrun_d = tvalid_q && !m_axis_tready;
                    end else begin
                        frame_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m_q   <= 1'b1;
            rxd_s_q   <= 1'b1;
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            timer_q   <= '0;
            period_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            rxd_m_q   <= rxd;
            rxd_s_q   <= rxd_m_q;
            state_q   <= state_d;
            armed_q   <= armed_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = state_q != IDLE;
    assign overrun_error = overrun_q;
    assign frame_error   = frame_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; a monitor pops expected words from a queue as the DUT presents them.
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        rxd = 1'b1;
    logic        busy, overrun_error, frame_error;
    logic [15:0] prescale = 16'd1;

    int          checks = 0;
    int          fails = 0;
    int          ovr_n = 0;
    int          fe_n = 0;
    logic [7:0]  exp_q[$];
    logic        pv = 1'b0;
    logic [7:0]  pd = 8'd0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .rxd(rxd), .busy(busy), .overrun_error(overrun_error), .frame_error(frame_error),
        .prescale(prescale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // start bit, 8 data bits LSB first, stop bit; the line is left at the stop level
    task automatic send(input logic [7:0] d, input int p, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (8 * p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (8 * p) @(negedge clk);
        end
        rxd = stop;
        repeat (8 * p) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (overrun_error) ovr_n++;
            if (frame_error) fe_n++;
            if (m_axis_tvalid && (!pv || m_axis_tready || m_axis_tdata != pd)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", m_axis_tdata);
                end else begin
                    chk("word", int'(m_axis_tdata), int'(exp_q.pop_front()));
                end
            end
            pv = m_axis_tvalid;
            pd = m_axis_tdata;
        end
    end

    initial begin
        int lat, o0, f0;
        repeat (3) @(negedge clk);
        chk("rst_tdata", int'(m_axis_tdata), 0);
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(overrun_error), 0);
        chk("rst_fe", int'(frame_error), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // T1
        prescale = 16'd1;
        m_axis_tready = 1'b1;
        o0 = ovr_n; f0 = fe_n;
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send(8'hA5, 1, 1'b1);
            begin
                @(negedge clk);
                while (!m_axis_tvalid && lat < 200) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        chk("t1_latency", lat, 4 + 8 * 9 + 3);
        repeat (10) @(negedge clk);
        chk("t1_ovr", ovr_n - o0, 0);
        chk("t1_fe", fe_n - f0, 0);
        chk("t1_tvalid_cleared", int'(m_axis_tvalid), 0);

        // T2
        prescale = 16'd2;
        m_axis_tready = 1'b0;
        o0 = ovr_n;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send(8'h3C, 2, 1'b1);
        chk("t2_first_hold", int'(m_axis_tdata), 8'h3C);
        send(8'hC3, 2, 1'b1);
        chk("t2_tdata", int'(m_axis_tdata), 8'hC3);
        chk("t2_ovr", ovr_n - o0, 1);
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_drained", int'(m_axis_tvalid), 0);

        // T3
        prescale = 16'd1;
        o0 = ovr_n; f0 = fe_n;
        send(8'h55, 1, 1'b0);
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        chk("t3_fe", fe_n - f0, 1);
        chk("t3_no_tvalid", int'(m_axis_tvalid), 0);
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h12);
        send(8'h12, 1, 1'b1);
        repeat (5) @(negedge clk);
        chk("t3_fe_after", fe_n - f0, 1);
        chk("t3_ovr", ovr_n - o0, 0);

        // T4
        prescale = 16'd4;
        o0 = ovr_n; f0 = fe_n;
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_busy_mid", int'(busy), 1);
        repeat (14) @(negedge clk);
        chk("t4_busy_end", int'(busy), 0);
        repeat (40) @(negedge clk);
        chk("t4_errors", (ovr_n - o0) + (fe_n - f0), 0);
        chk("t4_no_tvalid", int'(m_axis_tvalid), 0);

        // prescale of zero keeps the receiver idle
        prescale = 16'd0;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        chk("p0_busy", int'(busy), 0);
        rxd = 1'b1;
        repeat (5) @(negedge clk);

        // T5
        prescale = 16'd1;
        fork
            send(8'hFF, 1, 1'b1);
            begin
                repeat (30) @(negedge clk);
                rst = 1'b1;
                #1;
                chk("t5_busy", int'(busy), 0);
                chk("t5_tvalid", int'(m_axis_tvalid), 0);
            end
        join
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h81);
        send(8'h81, 1, 1'b1);
        repeat (5) @(negedge clk);

        // T6
        m_axis_tready = 1'b0;
        o0 = ovr_n;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        fork
            begin
                send(8'h01, 1, 1'b1);
                send(8'h02, 1, 1'b1);
            end
            begin
                @(negedge clk);
                repeat (159) @(negedge clk);
                m_axis_tready = 1'b1;
                @(negedge clk);
                m_axis_tready = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("t6_tdata", int'(m_axis_tdata), 8'h02);
        chk("t6_tvalid", int'(m_axis_tvalid), 1);
        chk("t6_ovr", ovr_n - o0, 0);
        m_axis_tready = 1'b1;
        repeat (10) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
